uart_imem_loader: RTL and testbench



---
 rtl/uart_imem_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_imem_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// UART-to-instruction-memory loader: packs bytes LSB-first into 32-bit words and holds the CPU in reset until loading ends.
// Optional inter-byte gap timeout is enabled by defining LOADER_TIMEOUT_EN.
module uart_imem_loader #(
  parameter int          ADDR_W         = 8,
  parameter int          DEPTH          = 256,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              write_done,
  output logic              load_overflow,
  output logic              cpu_rst
);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_DONE = 1'b1} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        byte_cnt_r;
  logic [1:0]        byte_cnt_nxt_s;
  logic [23:0]       buf_r;
  logic [23:0]       buf_nxt_s;
  logic              wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_addr_nxt_s;
  logic [31:0]       wr_data_nxt_s;
  logic [ADDR_W:0]   count_nxt_s;
  logic              done_nxt_s;
  logic              ovf_nxt_s;
  logic              cpu_rst_nxt_s;
  logic              in_load_s;
  logic              accept_s;
  logic              word_done_s;
  logic              is_end_s;
  logic              full_s;
  logic              discard_s;
  logic [31:0]       word_s;

  assign in_load_s   = (state_r == ST_LOAD);
  assign accept_s    = in_load_s && uart_rx_valid && !uart_rx_break && !discard_s;
  assign word_s      = {uart_rx_data, buf_r};
  assign word_done_s = accept_s && (byte_cnt_r == 2'd3);
  assign is_end_s    = word_done_s && (word_s == END_WORD);
  // The write to the last slot bumps word_count to DEPTH; the following cycle closes the load.
  assign full_s      = in_load_s && (word_count == DEPTH_C);

`ifdef LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt_r;

  assign discard_s = in_load_s && (byte_cnt_r != 2'd0) && (gap_cnt_r == GAP_W'(TIMEOUT_CYCLES));

  // Inter-byte gap counter, running only while a word is partially assembled
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_r <= {GAP_W{1'b0}};
    end else if (!in_load_s || accept_s || discard_s || uart_rx_break || (byte_cnt_r == 2'd0)) begin
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      gap_cnt_r <= gap_cnt_r + GAP_W'(1);
    end
  end
`else
  assign discard_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (full_s || is_end_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Next values of the assembly buffer and all registered outputs
  always_comb begin
    byte_cnt_nxt_s = byte_cnt_r;
    buf_nxt_s      = buf_r;
    wr_en_nxt_s    = 1'b0;
    wr_addr_nxt_s  = imem_wr_addr;
    wr_data_nxt_s  = imem_wr_data;
    count_nxt_s    = word_count;
    done_nxt_s     = write_done;
    ovf_nxt_s      = load_overflow;
    cpu_rst_nxt_s  = cpu_rst;
    if (in_load_s) begin
      if (uart_rx_break || discard_s) begin
        byte_cnt_nxt_s = 2'd0;
        buf_nxt_s      = 24'd0;
      end else if (uart_rx_valid) begin
        byte_cnt_nxt_s = byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    buf_nxt_s[7:0]   = uart_rx_data;
          2'd1:    buf_nxt_s[15:8]  = uart_rx_data;
          2'd2:    buf_nxt_s[23:16] = uart_rx_data;
          2'd3:    buf_nxt_s        = 24'd0;
          default: buf_nxt_s        = 24'd0;
        endcase
      end else begin
        byte_cnt_nxt_s = byte_cnt_r;
      end

      if (is_end_s) begin
        done_nxt_s    = 1'b1;
        cpu_rst_nxt_s = 1'b0;
      end else if (word_done_s && !full_s) begin
        wr_en_nxt_s   = 1'b1;
        wr_addr_nxt_s = word_count[ADDR_W-1:0];
        wr_data_nxt_s = word_s;
        count_nxt_s   = (word_count < DEPTH_C) ? word_count + (ADDR_W+1)'(1) : DEPTH_C;
      end else begin
        wr_en_nxt_s = 1'b0;
      end

      if (full_s) begin
        done_nxt_s    = 1'b1;
        ovf_nxt_s     = 1'b1;
        cpu_rst_nxt_s = 1'b0;
      end else begin
        ovf_nxt_s = load_overflow;
      end
    end else begin
      wr_en_nxt_s = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r    <= 2'd0;
      buf_r         <= 24'd0;
      imem_wr_en    <= 1'b0;
      imem_wr_addr  <= {ADDR_W{1'b0}};
      imem_wr_data  <= 32'd0;
      word_count    <= {(ADDR_W+1){1'b0}};
      write_done    <= 1'b0;
      load_overflow <= 1'b0;
      cpu_rst       <= 1'b1;
    end else begin
      byte_cnt_r    <= byte_cnt_nxt_s;
      buf_r         <= buf_nxt_s;
      imem_wr_en    <= wr_en_nxt_s;
      imem_wr_addr  <= wr_addr_nxt_s;
      imem_wr_data  <= wr_data_nxt_s;
      word_count    <= count_nxt_s;
      write_done    <= done_nxt_s;
      load_overflow <= ovf_nxt_s;
      cpu_rst       <= cpu_rst_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: word vectors from a table plus hand-written break/reset/timeout sequences.
module tb_uart_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_break;
  logic        imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic [8:0]  word_count;
  logic        write_done;
  logic        load_overflow;
  logic        cpu_rst;

  int checks = 0;
  int errors = 0;

  uart_imem_loader #(
    .ADDR_W(8), .DEPTH(4), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .word_count(word_count), .write_done(write_done), .load_overflow(load_overflow),
    .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic [31:0] word;
    logic        exp_wr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [8:0]  exp_cnt;
    logic        exp_done;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input logic brk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    uart_rx_break = brk;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_en"}, {31'd0, imem_wr_en}, 32'd0);
    chk({tag, "_addr"}, {24'd0, imem_wr_addr}, 32'd0);
    chk({tag, "_data"}, imem_wr_data, 32'd0);
    chk({tag, "_count"}, {23'd0, word_count}, 32'd0);
    chk({tag, "_done"}, {31'd0, write_done}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, load_overflow}, 32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
  endtask

  task automatic chk_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic [8:0] cnt);
    chk({tag, "_wr_en"}, {31'd0, imem_wr_en}, 32'd1);
    chk({tag, "_addr"}, {24'd0, imem_wr_addr}, {24'd0, addr});
    chk({tag, "_data"}, imem_wr_data, data);
    chk({tag, "_count"}, {23'd0, word_count}, {23'd0, cnt});
    @(negedge clk);
    chk({tag, "_wr_pulse_end"}, {31'd0, imem_wr_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;

    // Plain words, END marker, ignored traffic after DONE, then a DEPTH=4 overflow run.
    vecs[0]  = '{1'b0, 32'h0000_0000, 1'b1, 8'd0, 32'h0000_0000, 9'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 8'd1, 32'h0000_0000, 9'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'hFD01_0113, 1'b1, 8'd2, 32'hFD01_0113, 9'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 8'd2, 32'hFD01_0113, 9'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 8'd2, 32'hFD01_0113, 9'd3, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0281_2623, 1'b0, 8'd2, 32'hFD01_0113, 9'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h1111_1111, 1'b1, 8'd0, 32'h1111_1111, 9'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h2222_2222, 1'b1, 8'd1, 32'h2222_2222, 9'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h3333_3333, 1'b1, 8'd2, 32'h3333_3333, 9'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h4444_4444, 1'b1, 8'd3, 32'h4444_4444, 9'd4, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h5555_5555, 1'b0, 8'd3, 32'h4444_4444, 9'd4, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_rst) do_reset();
      send_word(vecs[i].word);
      chk($sformatf("v%0d_wr_en", i), {31'd0, imem_wr_en}, {31'd0, vecs[i].exp_wr});
      chk($sformatf("v%0d_addr", i), {24'd0, imem_wr_addr}, {24'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_data", i), imem_wr_data, vecs[i].exp_data);
      chk($sformatf("v%0d_count", i), {23'd0, word_count}, {23'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_done", i), {31'd0, write_done}, {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d_ovf", i), {31'd0, load_overflow}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, ~vecs[i].exp_done});
      @(negedge clk);
      chk($sformatf("v%0d_wr_pulse_end", i), {31'd0, imem_wr_en}, 32'd0);
    end
    // Overflow flags settle one cycle after the last-slot write.
    chk("ovf_final_done", {31'd0, write_done}, 32'd1);
    chk("ovf_final_flag", {31'd0, load_overflow}, 32'd1);
    chk("ovf_final_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // BREAK between bytes discards the partial word.
    do_reset();
    send_byte(8'h13, 1'b0);
    send_byte(8'h01, 1'b0);
    uart_rx_break = 1'b1;
    @(negedge clk);
    uart_rx_break = 1'b0;
    send_word(32'h0281_2623);
    chk_write("brk", 8'd0, 32'h0281_2623, 9'd1);

    // BREAK coincident with a byte: partial cleared and that byte dropped.
    send_byte(8'h11, 1'b0);
    send_byte(8'h55, 1'b1);
    send_word(32'h0281_2623);
    chk_write("brk_coinc", 8'd1, 32'h0281_2623, 9'd2);

    // Reset in the middle of the third word.
    do_reset();
    send_word(32'hA000_0001);
    send_word(32'hB000_0002);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    do_reset();
    chk_reset_state("midrst");
    send_word(32'h0301_0413);
    chk_write("midrst_new", 8'd0, 32'h0301_0413, 9'd1);

    // Long gap inside a word.
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (101) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    send_word(32'hFFE0_0793);
    chk_write("timeout", 8'd0, 32'hFFE0_0793, 9'd1);
`else
    send_byte(8'h93, 1'b0);
    send_byte(8'h07, 1'b0);
    chk_write("no_timeout", 8'd0, 32'h0793_BBAA, 9'd1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk("no_timeout_tail_wr", {31'd0, imem_wr_en}, 32'd0);
    chk("no_timeout_tail_cnt", {23'd0, word_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
